kernel_buffer: RTL

KERNEL_BUFFER -- requirements
Module: kernel_buffer

---
 rtl/kernel_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/kernel_buffer.sv
// Double-buffered 3x3 kernel weight store: a 10-word stream fills a shadow bank,
// which is promoted to the active bank when the downstream sweep finishes a column cycle.
module kernel_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] K1,
  output logic [DATA_WIDTH-1:0] K2,
  output logic [DATA_WIDTH-1:0] K3,
  output logic [DATA_WIDTH-1:0] K4,
  output logic [DATA_WIDTH-1:0] K5,
  output logic [DATA_WIDTH-1:0] K6,
  output logic [DATA_WIDTH-1:0] K7,
  output logic [DATA_WIDTH-1:0] K8,
  output logic [DATA_WIDTH-1:0] K9,
  output logic [DATA_WIDTH-1:0] bias,
  output logic [1:0]            sel,
  output logic                  kernel_valid,
  output logic                  err
);
  localparam int NW = 10;

  typedef enum logic {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [3:0]                     r_idx;
  logic [NW-1:0][DATA_WIDTH-1:0]  r_shadow;
  logic [NW-1:0][DATA_WIDTH-1:0]  r_active;
  logic                           r_s_ready;
  logic                           r_kv;
  logic                           r_err;
  logic [1:0]                     r_sel;

  logic w_xfer;
  logic w_last_idx;
  logic w_swap;
  logic w_ready_nxt;
  logic w_frame_err;

  assign w_xfer     = s_valid & r_s_ready;
  assign w_last_idx = (r_idx == 4'd9);
  // Promote immediately when nothing is active, otherwise only at the end of a sel sweep.
  assign w_swap     = (r_state == ST_FULL) & (~r_kv | (step & (r_sel == 2'd3)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_xfer && w_last_idx) w_state_nxt = ST_FULL;
      ST_FULL: if (w_swap)               w_state_nxt = ST_LOAD;
      default:                           w_state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_LOAD);
    w_frame_err = w_xfer & (s_last ^ w_last_idx);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s_ready <= 1'b0;
      r_idx     <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_s_ready <= w_ready_nxt;
      if (w_xfer) begin
        if (w_last_idx || s_last) r_idx <= 4'd0;
        else                      r_idx <= r_idx + 4'd1;
      end
      if (w_frame_err) r_err <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              r_shadow[gi] <= '0;
        else if (w_xfer && (r_idx == 4'(gi)))   r_shadow[gi] <= s_data;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= '0;
      r_kv     <= 1'b0;
      r_sel    <= 2'd0;
    end else begin
      if (w_swap) begin
        r_active <= r_shadow;
        r_kv     <= 1'b1;
        r_sel    <= 2'd0;
      end else if (step && r_kv) begin
        r_sel    <= r_sel + 2'd1;
      end
    end
  end

  assign s_ready      = r_s_ready;
  assign kernel_valid = r_kv;
  assign sel          = r_sel;
  assign err          = r_err;
  assign K1   = r_active[0];
  assign K2   = r_active[1];
  assign K3   = r_active[2];
  assign K4   = r_active[3];
  assign K5   = r_active[4];
  assign K6   = r_active[5];
  assign K7   = r_active[6];
  assign K8   = r_active[7];
  assign K9   = r_active[8];
  assign bias = r_active[9];
endmodule
